// File: rtl/vol_ctrl_multi_if.sv
// Request/level bundle between the button/CPU side and the multi-channel volume controller.
interface vol_ctrl_multi_if #(
    parameter int NCH  = 2,
    parameter int CH_W = 8
);
    logic                  UP;
    logic                  DOWN;
    logic                  MUTE;
    logic [NCH-1:0]        SEL;
    logic                  WE;
    logic [NCH*CH_W-1:0]   R;
    logic [NCH*CH_W-1:0]   VOL;
    logic                  MUTED;
    logic                  CHANGED;

    modport master (
        output UP, DOWN, MUTE, SEL, WE, R,
        input  VOL, MUTED, CHANGED
    );

    modport slave (
        input  UP, DOWN, MUTE, SEL, WE, R,
        output VOL, MUTED, CHANGED
    );
endinterface

// File: rtl/vol_ctrl_multi.sv
// Multi-channel volume controller: per-channel saturating steps with hold/auto-repeat,
// mute toggle that keeps levels, clamped bulk load and a change strobe.
module vol_ctrl_multi #(
    parameter int              NCH        = 2,
    parameter int              CH_W       = 8,
    parameter logic [CH_W-1:0] STEP       = 8'h10,
    parameter logic [CH_W-1:0] VMIN       = 8'h00,
    parameter logic [CH_W-1:0] VMAX       = 8'hF0,
    parameter logic [CH_W-1:0] VINIT      = 8'h80,
    parameter int              HOLD_CYC   = 10000000,
    parameter int              REPEAT_CYC = 2500000,
    parameter int              CNT_W      = 24
) (
    input  logic              CLK,
    input  logic              RST,
    vol_ctrl_multi_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LD  = CNT_W'(REPEAT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      timer_q, timer_d;
    logic                  dir_q, dir_d;
    logic                  lock_q, lock_d;
    logic                  muted_q, muted_d;
    logic                  mute_prev_q;
    logic                  changed_q, changed_d;
    logic [NCH*CH_W-1:0]   lvl_q, lvl_d;
    logic [NCH*CH_W-1:0]   vol_q, vol_d;

    logic                  req_up_s, req_dn_s, req_s, mute_edge_s;
    logic                  do_step_s, step_up_s;

    function automatic logic [CH_W-1:0] clamp_lvl(input logic [CH_W-1:0] v);
        if (v > VMAX) begin
            return VMAX;
        end else if (v < VMIN) begin
            return VMIN;
        end else begin
            return v;
        end
    endfunction

    // Compare in CH_W+1 bits so the saturation test itself can never wrap.
    function automatic logic [CH_W-1:0] step_lvl(input logic [CH_W-1:0] v, input logic up);
        logic [CH_W:0] w;
        w = {1'b0, v};
        if (up) begin
            if (w + {1'b0, STEP} >= {1'b0, VMAX}) begin
                return VMAX;
            end else begin
                return v + STEP;
            end
        end else begin
            if (w <= {1'b0, VMIN} + {1'b0, STEP}) begin
                return VMIN;
            end else begin
                return v - STEP;
            end
        end
    endfunction

    assign req_up_s    = bus.UP & ~bus.DOWN;
    assign req_dn_s    = bus.DOWN & ~bus.UP;
    assign req_s       = req_up_s | req_dn_s;
    assign mute_edge_s = bus.MUTE & ~mute_prev_q;

    // Next-state: load / mute / press FSM, then level update and output image.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        dir_d     = dir_q;
        muted_d   = muted_q;
        lvl_d     = lvl_q;
        do_step_s = 1'b0;
        step_up_s = dir_q;
        lock_d    = bus.WE ? req_s : (lock_q & req_s);

        if (bus.WE) begin
            for (int i = 0; i < NCH; i++) begin
                lvl_d[i*CH_W +: CH_W] = clamp_lvl(bus.R[i*CH_W +: CH_W]);
            end
            state_d = ST_IDLE;
            timer_d = CNT_ZERO;
        end else if (mute_edge_s || muted_q) begin
            muted_d = muted_q ^ mute_edge_s;
            state_d = ST_IDLE;
            timer_d = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_s && !lock_q) begin
                        do_step_s = 1'b1;
                        step_up_s = req_up_s;
                        dir_d     = req_up_s;
                        timer_d   = HOLD_LD;
                        state_d   = ST_HOLD;
                    end else begin
                        timer_d   = CNT_ZERO;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    if (!req_s) begin
                        state_d = ST_IDLE;
                        timer_d = CNT_ZERO;
                    end else if (req_up_s != dir_q) begin
                        do_step_s = 1'b1;
                        step_up_s = req_up_s;
                        dir_d     = req_up_s;
                        timer_d   = HOLD_LD;
                        state_d   = ST_HOLD;
                    end else if (timer_q == CNT_ZERO) begin
                        do_step_s = 1'b1;
                        timer_d   = REP_LD;
                        state_d   = ST_REPEAT;
                    end else begin
                        timer_d   = timer_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = CNT_ZERO;
                end
            endcase
        end

        if (do_step_s) begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.SEL[i]) begin
                    lvl_d[i*CH_W +: CH_W] = step_lvl(lvl_q[i*CH_W +: CH_W], step_up_s);
                end else begin
                    lvl_d[i*CH_W +: CH_W] = lvl_q[i*CH_W +: CH_W];
                end
            end
        end else begin
            lvl_d = lvl_d;
        end

        for (int i = 0; i < NCH; i++) begin
            vol_d[i*CH_W +: CH_W] = muted_d ? VMIN : lvl_d[i*CH_W +: CH_W];
        end
        changed_d = (vol_d != vol_q);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            timer_q     <= CNT_ZERO;
            dir_q       <= 1'b0;
            lock_q      <= 1'b0;
            muted_q     <= 1'b0;
            mute_prev_q <= 1'b1;
            changed_q   <= 1'b0;
            lvl_q       <= {NCH{VINIT}};
            vol_q       <= {NCH{VINIT}};
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            dir_q       <= dir_d;
            lock_q      <= lock_d;
            muted_q     <= muted_d;
            mute_prev_q <= bus.MUTE;
            changed_q   <= changed_d;
            lvl_q       <= lvl_d;
            vol_q       <= vol_d;
        end
    end

    assign bus.VOL     = vol_q;
    assign bus.MUTED   = muted_q;
    assign bus.CHANGED = changed_q;
endmodule

// File: tb/tb_vol_ctrl_multi.sv
// Directed test-plan sequences followed by random traffic, each edge checked against a press-timing model.
module tb_vol_ctrl_multi;
    localparam int NCH = 2, CH_W = 8, HOLD = 4, REP = 2;
    localparam int STEP = 16, VMIN = 0, VMAX = 240, VINIT = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vol_ctrl_multi_if #(.NCH(NCH), .CH_W(CH_W)) bus ();

    vol_ctrl_multi #(.NCH(NCH), .CH_W(CH_W), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    int         m_lv [NCH];
    bit         m_muted, m_prev_mute, m_lock, m_hdir;
    int         m_held;
    logic [15:0] m_vol, m_prev_vol;
    bit         m_changed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int step_val(input int v, input bit up);
        if (up) return (v >= VMAX - STEP) ? VMAX : v + STEP;
        else    return (v <= VMIN + STEP) ? VMIN : v - STEP;
    endfunction

    // Press model: cycles since press start; steps at 0, HOLD, HOLD+REP, ...
    task automatic model_step();
        bit up, dn, req;
        up  = bus.UP & ~bus.DOWN;
        dn  = bus.DOWN & ~bus.UP;
        req = up | dn;
        m_prev_vol = m_vol;
        if (rst) begin
            for (int i = 0; i < NCH; i++) m_lv[i] = VINIT;
            m_muted = 0; m_prev_mute = 1; m_lock = 0; m_held = -1; m_hdir = 0;
        end else begin
            if (bus.WE) begin
                for (int i = 0; i < NCH; i++) begin
                    int r;
                    r = int'(bus.R[i*CH_W +: CH_W]);
                    m_lv[i] = (r > VMAX) ? VMAX : ((r < VMIN) ? VMIN : r);
                end
                m_held = -1;
                m_lock = req;
            end else begin
                m_lock = m_lock & req;
                if (bus.MUTE && !m_prev_mute) begin
                    m_muted = !m_muted;
                    m_held  = -1;
                end else if (m_muted || !req || m_lock) begin
                    m_held = -1;
                end else begin
                    bit stp;
                    if (m_held < 0 || up != m_hdir) begin
                        m_held = 0; m_hdir = up; stp = 1;
                    end else begin
                        m_held++;
                        stp = (m_held >= HOLD) && ((m_held - HOLD) % REP == 0);
                    end
                    if (stp)
                        for (int i = 0; i < NCH; i++)
                            if (bus.SEL[i]) m_lv[i] = step_val(m_lv[i], m_hdir);
                end
            end
            m_prev_mute = bus.MUTE;
        end
        for (int i = 0; i < NCH; i++) m_vol[i*CH_W +: CH_W] = m_muted ? 8'(VMIN) : 8'(m_lv[i]);
        m_changed = rst ? 1'b0 : (m_vol != m_prev_vol);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("VOL", 32'(bus.VOL), 32'(m_vol));
        check("MUTED", 32'(bus.MUTED), 32'(m_muted));
        check("CHANGED", 32'(bus.CHANGED), 32'(m_changed));
    endtask

    task automatic set_in(input bit up, input bit dn, input bit mute, input logic [1:0] sel,
                          input bit we, input logic [15:0] r);
        bus.UP = up; bus.DOWN = dn; bus.MUTE = mute; bus.SEL = sel; bus.WE = we; bus.R = r;
    endtask

    initial begin
        m_vol = 16'h8080;
        rst = 1'b1;
        set_in(0, 0, 0, 2'b11, 0, 16'h0000);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset_vol", 32'(bus.VOL), 32'h8080);
        check("reset_muted", 32'(bus.MUTED), 32'h0);

        set_in(1, 0, 0, 2'b11, 0, 16'h0000); tick();
        check("up_pulse_vol", 32'(bus.VOL), 32'h9090);
        check("up_pulse_chg", 32'(bus.CHANGED), 32'h1);
        set_in(0, 0, 0, 2'b11, 0, 16'h0000); tick();
        check("up_pulse_chg_drop", 32'(bus.CHANGED), 32'h0);

        set_in(0, 0, 0, 2'b11, 1, 16'h8080); tick();
        set_in(1, 0, 0, 2'b01, 0, 16'h0000);
        for (int k = 0; k < 11; k++) tick();
        check("hold_repeat_vol", 32'(bus.VOL), 32'h80D0);
        set_in(0, 0, 0, 2'b01, 0, 16'h0000); tick();

        set_in(0, 0, 0, 2'b11, 1, 16'hE805); tick();
        set_in(1, 0, 0, 2'b11, 0, 16'h0000); tick();
        check("sat_up_vol", 32'(bus.VOL), 32'hF015);
        set_in(0, 0, 0, 2'b11, 1, 16'h0805); tick();
        set_in(0, 1, 0, 2'b11, 0, 16'h0000); tick();
        check("sat_dn_vol", 32'(bus.VOL), 32'h0000);
        set_in(0, 0, 0, 2'b11, 0, 16'h0000); tick();
        set_in(0, 1, 0, 2'b11, 0, 16'h0000); tick();
        check("sat_dn_nochg", 32'(bus.CHANGED), 32'h0);
        set_in(0, 0, 0, 2'b11, 0, 16'h0000); tick();

        set_in(0, 0, 0, 2'b11, 1, 16'h9090); tick();
        set_in(0, 0, 1, 2'b11, 0, 16'h0000); tick();
        check("mute_vol", 32'(bus.VOL), 32'h0000);
        check("mute_flag", 32'(bus.MUTED), 32'h1);
        set_in(0, 0, 0, 2'b11, 0, 16'h0000); tick();
        set_in(1, 0, 0, 2'b11, 0, 16'h0000); tick();
        check("mute_up_ignored", 32'(bus.VOL), 32'h0000);
        set_in(0, 0, 0, 2'b11, 0, 16'h0000); tick();
        set_in(0, 0, 1, 2'b11, 0, 16'h0000); tick();
        check("unmute_vol", 32'(bus.VOL), 32'h9090);
        check("unmute_flag", 32'(bus.MUTED), 32'h0);
        set_in(0, 0, 0, 2'b11, 0, 16'h0000); tick();

        set_in(1, 0, 0, 2'b11, 1, 16'hFF00); tick();
        check("we_wins_vol", 32'(bus.VOL), 32'hF000);
        set_in(1, 0, 0, 2'b11, 0, 16'h0000); tick(); tick();
        check("we_lock_vol", 32'(bus.VOL), 32'hF000);
        set_in(0, 0, 0, 2'b11, 1, 16'h4040); tick();
        set_in(1, 0, 0, 2'b01, 0, 16'h0000);
        for (int k = 0; k < 7; k++) tick();
        rst = 1'b1; tick();
        check("rst_mid_repeat", 32'(bus.VOL), 32'h8080);
        rst = 1'b0; bus.SEL = 2'b11; tick();
        check("rst_then_step", 32'(bus.VOL), 32'h9090);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.UP   = $urandom_range(0, 1);
                bus.DOWN = $urandom_range(0, 2) == 0;
            end
            if ($urandom_range(0, 19) == 0) bus.SEL = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) bus.MUTE = ~bus.MUTE;
            bus.WE = ($urandom_range(0, 39) == 0);
            bus.R  = 16'($urandom);
            rst    = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/vol_ctrl_multi.md
Name: vol_ctrl_multi

Overview:
Parametrised multi-channel volume controller for the MP3 datapath. It sits between the front-panel buttons or CPU store port and the codec register writer, and holds one attenuation level per channel. Compared with the single-stereo-word setter it adds:
- per-channel select mask and independent per-channel saturation
- hold-then-auto-repeat timing
- mute toggle that retains levels
- clamped CPU load
- a change strobe for the codec writer

Parameters:
NCH, 2, number of channels
CH_W, 8, bits per channel level
STEP, 8'h10, increment/decrement per step
VMIN, 8'h00, minimum level; also the output value while muted
VMAX, 8'hF0, maximum level
VINIT, 8'h80, per-channel level after reset
HOLD_CYC, 10000000, cycles from first step to first repeat step
REPEAT_CYC, 2500000, cycles between subsequent repeat steps
CNT_W, 24, timer width; must hold max(HOLD_CYC, REPEAT_CYC)

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  synchronous reset, active-high
UP  in  1  increase request (synchronised level)
DOWN  in  1  decrease request (synchronised level)
MUTE  in  1  mute button (synchronised level); rising edge toggles mute
SEL  in  NCH  channel mask for UP/DOWN steps
WE  in  1  load all levels from R
R  in  NCH*CH_W  load data; channel i at bits [i*CH_W +: CH_W]
VOL  out  NCH*CH_W  registered output levels, same packing as R
MUTED  out  1  mute state
CHANGED  out  1  high for exactly the cycles in which VOL differs from its previous-cycle value

Behaviour:
- Reset:
  - levels = VINIT per channel; VOL = VINIT replicated
  - MUTED = 0, CHANGED = 0, FSM = IDLE, timer = 0
  - mute-edge register = 1, so a MUTE held through reset does not toggle
- Request decode:
  - req_up = UP & ~DOWN; req_dn = DOWN & ~UP
  - UP and DOWN both high, or both low, means no request
- Priority per cycle: RST > WE > MUTE edge > UP/DOWN FSM.
- WE:
  - each channel is loaded with R clamped to [VMIN, VMAX]
  - FSM returns to IDLE and the timer clears
  - MUTED is unchanged; a held button must be released and re-pressed before it steps again
- MUTE edge:
  - MUTED toggles; levels are retained
  - while MUTED = 1, VOL = VMIN on every channel; UP/DOWN are ignored and the FSM is held in IDLE
  - unmuting restores VOL from the retained levels on the same edge
- Step arithmetic, per channel with its SEL bit set:
  - up: v >= VMAX-STEP ? VMAX : v+STEP
  - down: v <= VMIN+STEP ? VMIN : v-STEP
  - compute in CH_W+1 bits; wrap-around is never permitted
  - unselected channels hold; channels saturate independently
- FSM:
  - IDLE: on req_up or req_dn, step in that direction on this edge, latch the direction, timer = HOLD_CYC-1, go to HOLD.
  - HOLD: if the request is gone, go to IDLE with timer 0. If the request reverses, step in the new direction, timer = HOLD_CYC-1, stay in HOLD. If timer = 0, step, timer = REPEAT_CYC-1, go to REPEAT. Otherwise decrement the timer.
  - REPEAT: same as HOLD, except that on timer = 0 it steps and reloads REPEAT_CYC-1. Reversal returns to HOLD.
- Timing and latency:
  - latency is one edge: a request sampled at edge k shows in VOL after edge k
  - the first repeat step lands exactly HOLD_CYC edges after the first step; later steps land every REPEAT_CYC edges
- CHANGED:
  - registered alongside VOL
  - a step at saturation, a WE of identical data, or a SEL of 0 produces no CHANGED
  - mute and unmute produce CHANGED only if VOL actually changes
- Reset mid-HOLD/REPEAT: all state goes to the reset values on that edge; a held button is treated as a new press once RST falls.

Test Plan:
Unless stated otherwise, the bench uses HOLD_CYC=4, REPEAT_CYC=2, and the defaults for the other parameters.
1. Reset: assert RST, release -> VOL=16'h8080, MUTED=0, CHANGED=0.
2. UP for 1 cycle, SEL=2'b11 -> VOL=16'h9090 after that edge; CHANGED high for 1 cycle.
3. UP held 11 cycles from 16'h8080, SEL=2'b01 -> low byte steps at relative edges 0,4,6,8,10 to 90,A0,B0,C0,D0; high byte stays 80; release returns the FSM to IDLE.
4. Saturation: WE with R=16'hE805, then UP pulse, SEL=2'b11 -> VOL=16'hF015. Next, WE with R=16'h0805, then DOWN pulse -> VOL=16'h0000. A further DOWN pulse -> no change, CHANGED stays 0.
5. Mute: from 16'h9090, MUTE pulse -> VOL=16'h0000, MUTED=1; UP pulse -> no change; MUTE pulse -> VOL=16'h9090, MUTED=0.
6. WE with R=16'hFF00 together with UP -> VOL=16'hF000 (clamped, WE wins, no step). Then RST asserted mid-REPEAT with UP still held -> VOL=16'h8080; after RST falls, a step occurs on the next edge.
